// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the LEGv8 pipeline.
//
// Owns the program counter, drives the combinational instruction-memory address
// and captures the returned instruction into the IF/ID pipeline register.
// Unconditional B is resolved here. Conditional and late redirects arrive from
// downstream on br_taken/br_target.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   stall        hold PC, IF/ID and fetch_count
//   br_taken     late redirect; loads br_target and flushes IF/ID (beats stall)
//   br_target    redirect address, taken verbatim
//   instr_in     instruction at pc_out, valid in the same cycle
//   pc_out       current PC (instruction-memory address)
//   if_id_valid  IF/ID holds a real instruction
//   if_id_pc     PC of the instruction in IF/ID
//   if_id_instr  instruction in IF/ID
//   fetch_count  number of valid instructions latched into IF/ID (wraps)
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [63:0]        br_target,
  input  logic [31:0]        instr_in,
  output logic [63:0]        pc_out,
  output logic               if_id_valid,
  output logic [63:0]        if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [5:0] OpcodeB = 6'b000101;

  logic [63:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [63:0]        id_pc_q, id_pc_d;
  logic [31:0]        id_instr_q, id_instr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic        is_b;
  logic [63:0] b_offset;
  logic [63:0] b_tgt;
  logic [63:0] pc_seq;

  // Early B decode: imm26 is a word offset, sign-extended and scaled by 4.
  assign is_b     = (instr_in[31:26] == OpcodeB);
  assign b_offset = {{36{instr_in[25]}}, instr_in[25:0], 2'b00};
  assign b_tgt    = pc_q + b_offset;
  assign pc_seq   = pc_q + 64'd4;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    count_d    = count_q;

    if (br_taken) begin
      // The instruction currently at pc_out is on the wrong path; drop it.
      pc_d       = br_target;
      valid_d    = 1'b0;
      id_pc_d    = 64'd0;
      id_instr_d = 32'd0;
    end else if (!stall) begin
      pc_d       = is_b ? b_tgt : pc_seq;
      valid_d    = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = instr_in;
      count_d    = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= 64'd0;
      id_instr_q <= 32'd0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      count_q    <= count_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_instr = id_instr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned CW = 4;
  localparam logic [31:0] Filler = 32'h8B1F03E0;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          br_taken;
  logic [63:0]   br_target;
  logic [31:0]   instr_in;
  logic [63:0]   pc_out;
  logic          if_id_valid;
  logic [63:0]   if_id_pc;
  logic [31:0]   if_id_instr;
  logic [CW-1:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Byte-addressed big-endian instruction memory, 512 bytes, aliased on pc[8:0].
  logic [7:0] mem [0:511];
  logic [8:0] a0;

  assign a0       = pc_out[8:0];
  assign instr_in = {mem[a0], mem[a0 + 9'd1], mem[a0 + 9'd2], mem[a0 + 9'd3]};

  fetch_stage #(
    .RESET_PC(64'd0),
    .COUNT_W (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .instr_in   (instr_in),
    .pc_out     (pc_out),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic wr(input int unsigned addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [63:0] e_pc_out, input logic e_valid,
                        input logic [63:0] e_pc, input logic [31:0] e_instr,
                        input logic [CW-1:0] e_cnt);
    chk({tag, ".pc_out"}, pc_out, e_pc_out);
    chk({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, e_valid});
    chk({tag, ".if_id_pc"}, if_id_pc, e_pc);
    chk({tag, ".if_id_instr"}, {32'd0, if_id_instr}, {32'd0, e_instr});
    chk({tag, ".count"}, {60'd0, fetch_count}, {60'd0, e_cnt});
  endtask

  initial begin
    for (int i = 0; i < 512; i += 4) wr(i, Filler);
    wr(32'h000, 32'hF8403040);
    wr(32'h004, 32'h8B050009);
    wr(32'h008, 32'h17FFFFFF);   // backward B to 4
    wr(32'h024, 32'h1400000A);   // forward B, 0x24 -> 0x4C
    wr(32'h100, 32'h91000421);

    reset     = 1'b1;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'd0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.pc_out", pc_out, 64'd0);
      chk("rst.valid", {63'd0, if_id_valid}, 64'd0);
    end
    chk_if("rst", 64'd0, 1'b0, 64'd0, 32'd0, 4'd0);
    reset = 1'b0;

    step();
    chk_if("edge1", 64'h4, 1'b1, 64'h0, 32'hF8403040, 4'd1);
    step();
    chk_if("edge2", 64'h8, 1'b1, 64'h4, 32'h8B050009, 4'd2);

    // Backward B at pc=8
    step();
    chk_if("bback", 64'h4, 1'b1, 64'h8, 32'h17FFFFFF, 4'd3);
    wr(32'h008, Filler);
    step();
    chk_if("seq4", 64'h8, 1'b1, 64'h4, 32'h8B050009, 4'd4);
    step();
    chk_if("seq8", 64'hC, 1'b1, 64'h8, Filler, 4'd5);

    // Redirect together with stall at pc=0x0C: redirect wins, bubble inserted
    br_taken  = 1'b1;
    br_target = 64'h100;
    stall     = 1'b1;
    step();
    chk_if("redir", 64'h100, 1'b0, 64'h0, 32'h0, 4'd5);
    br_taken = 1'b0;
    stall    = 1'b0;
    step();
    chk_if("redir_fetch", 64'h104, 1'b1, 64'h100, 32'h91000421, 4'd6);

    // Redirect to 0x0C, fetch once, then stall at pc=0x10
    br_taken  = 1'b1;
    br_target = 64'hC;
    step();
    chk_if("redir2", 64'hC, 1'b0, 64'h0, 32'h0, 4'd6);
    br_taken = 1'b0;
    step();
    chk_if("pre_stall", 64'h10, 1'b1, 64'hC, Filler, 4'd7);
    stall = 1'b1;
    step();
    chk_if("stall1", 64'h10, 1'b1, 64'hC, Filler, 4'd7);
    step();
    chk_if("stall2", 64'h10, 1'b1, 64'hC, Filler, 4'd7);
    stall = 1'b0;
    step();
    chk_if("unstall", 64'h14, 1'b1, 64'h10, Filler, 4'd8);

    repeat (4) step();
    chk("to_24.pc_out", pc_out, 64'h24);

    // Forward B at 0x24 is still delivered to IF/ID
    step();
    chk_if("bfwd", 64'h4C, 1'b1, 64'h24, 32'h1400000A, 4'd13);

    // Reset mid-stream overrides stall and redirect
    reset     = 1'b1;
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 64'h100;
    step();
    chk_if("rst_mid", 64'd0, 1'b0, 64'd0, 32'd0, 4'd0);
    reset    = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;

    // 17 fetches wrap the 4-bit counter to 1
    wr(32'h000, Filler);
    wr(32'h004, Filler);
    wr(32'h024, Filler);
    repeat (17) step();
    chk_if("cnt_wrap", 64'h44, 1'b1, 64'h40, Filler, 4'd1);

    // PC increment wraps modulo 2^64
    br_taken  = 1'b1;
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("top.pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    br_taken = 1'b0;
    step();
    chk_if("pc_wrap", 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, Filler, 4'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 CPU; sits directly upstream of the combinational, byte-addressed, big-endian instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for the decoder.
- Resolves unconditional B early, in fetch; takes conditional/late redirects from downstream.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
COUNT_W, 32, width of fetched-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall; hold PC and IF/ID contents
br_taken  input  1  late redirect from downstream (CBZ/B.cond/etc.); flushes IF/ID
br_target  input  64  redirect address when br_taken=1
instr_in  input  32  instruction returned by instruction memory for pc_out (same cycle)
pc_out  output  64  current PC; drives instruction-memory address
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  64  PC of instruction in IF/ID
if_id_instr  output  32  instruction in IF/ID
fetch_count  output  COUNT_W  number of instructions latched into IF/ID with valid=1

Behaviour:
- Registered state: pc, if_id_valid, if_id_pc, if_id_instr, fetch_count. All update on rising clk only.
- pc_out = pc, combinationally. Instruction memory is combinational, so instr_in is valid in the same cycle.
- Reset (reset=1 at an edge): pc<=RESET_PC, if_id_valid<=0, if_id_pc<=0, if_id_instr<=0, fetch_count<=0. Reset overrides every other input, including mid-stall and mid-redirect. The first fetch is captured on the first edge with reset=0.
- Early-B decode: is_b = (instr_in[31:26]==6'b000101). b_tgt = pc + (sign-extend(instr_in[25:0]) << 2), computed in 64 bits with modulo-2^64 wrap.
- Sequential next PC: pc+4, modulo 2^64.
- Per-edge priority, highest first:
  1. reset
  2. br_taken: pc<=br_target; if_id_valid<=0, if_id_pc<=0, if_id_instr<=0 (bubble); count unchanged. Wins over stall.
  3. stall: pc, IF/ID registers and count all hold.
  4. Normal: if_id_pc<=pc, if_id_instr<=instr_in, if_id_valid<=1, fetch_count<=fetch_count+1 (wraps at 2^COUNT_W). pc<=b_tgt if is_b, else pc+4.
- The B instruction itself is still delivered to IF/ID with valid=1. Downstream must not assert br_taken for B.
- Latency: instruction fetched at PC X appears on if_id_* one edge after pc_out=X. Redirect takes effect on pc_out one edge after br_taken; exactly one bubble is inserted.
- No alignment checking: pc low bits pass through unchanged. br_target is taken verbatim.
- No X may propagate to outputs after reset.

Test Plan:
- Reset held 3 cycles, then released with mem word0=0xF8403040 and word1=0x8B050009 -> during reset pc_out=0 and if_id_valid=0. Edge 1: if_id_pc=0, if_id_instr=0xF8403040, pc_out=4. Edge 2: if_id_instr=0x8B050009, pc_out=8, fetch_count=2.
- Early B: pc=0x24 with instr_in=0x1400000A -> next pc_out=0x4C, if_id_instr=0x1400000A, if_id_valid=1. Backward B: pc=8 with instr_in=0x17FFFFFF -> next pc_out=4.
- Stall held 2 edges at pc=0x10 -> pc_out stays 0x10, IF/ID and fetch_count unchanged. On release the next edge latches the instruction at 0x10 and pc_out=0x14.
- br_taken=1 with br_target=0x100 at pc=0x0C, with stall=1 simultaneously -> pc_out=0x100, if_id_valid=0, if_id_instr=0, fetch_count unchanged. Next edge latches the instruction at 0x100 with valid=1.
- Reset asserted mid-stream with pc=0x4C, stall=1 and br_taken=1 -> next edge pc_out=RESET_PC, if_id_valid=0, fetch_count=0.
- fetch_count wrap: COUNT_W=4, 17 normal fetches -> fetch_count=1.
